mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache refill path and the data-cache refill/writeback path.
- Grants one whole-line transaction at a time using 2-way round-robin, forwards it to memory, and holds it until memory signals completion.
- Routes the completion and read data back to the granted cache.
- Sits between the two cache controllers and the memory model/bus, inside the core top.

Parameters:
- ADDR_W, 32, address width (ADDR_SIZE).
- LINE_BYTES, 64, cache line size in bytes (CACHE_LINE_SIZE).
- LINE_W, LINE_BYTES*8 = 512, line data width.
- OFF_W, log2(LINE_BYTES) = 6, line offset bits forced to zero on mem_addr.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  icache line read request; level, held until ic_done
- ic_addr  in  ADDR_W  icache miss address; stable while ic_req
- ic_done  out  1  one-cycle pulse: ic_rdata valid
- ic_rdata  out  LINE_W  line returned to icache
- dc_req  in  1  dcache request; level, held until dc_done
- dc_we  in  1  0 = line read (refill), 1 = line write (writeback)
- dc_addr  in  ADDR_W  dcache address; stable while dc_req
- dc_wdata  in  LINE_W  writeback line; stable while dc_req
- dc_done  out  1  one-cycle pulse: read data valid or write complete
- dc_rdata  out  LINE_W  line returned to dcache (don't-care after a write)
- mem_req  out  1  memory request; held until mem_done
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  line-aligned address
- mem_wdata  out  LINE_W  write line
- mem_done  in  1  one-cycle pulse: transaction complete; mem_rdata valid for reads
- mem_rdata  in  LINE_W  read line

Behaviour:
- Reset values:
  - state = IDLE; last_gnt = DC, so icache wins the first tie.
  - mem_req, mem_we, ic_done, dc_done = 0.
  - mem_addr, mem_wdata, ic_rdata, dc_rdata = 0.
- States:
  - IDLE: evaluates requests.
  - ISSUE: memory transaction in flight.
  - RESP: one-cycle completion pulse to the requester.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_gnt.
  - On grant: register gnt_id, mem_addr = {addr[ADDR_W-1:OFF_W], OFF_W'b0}, mem_we (icache always 0), mem_wdata (dcache only, else 0). Go to ISSUE; last_gnt <= gnt_id.
- ISSUE:
  - mem_req = 1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_done: capture mem_rdata into the granted requester's rdata register, drop mem_req in the next cycle, go to RESP.
- RESP:
  - The granted requester's done = 1 for exactly this cycle.
  - Always returns to IDLE.
  - Requests are not evaluated in RESP; requesters drop req the cycle after done.
- Latency:
  - Request visible in IDLE at cycle 0 -> mem_req high from cycle 1.
  - mem_done at cycle N -> done pulse at cycle N+1 -> IDLE at N+2.
  - Minimum turnaround with 1-cycle memory: 4 cycles per transaction.
- Fairness: with both requesters continuously requesting, grants strictly alternate; neither waits more than one transaction.
- Only the granted requester's rdata register updates; the other keeps its last value.
- mem_done outside ISSUE is ignored: no state change, no done pulse.
- A request asserted while another transaction is in flight waits; it is evaluated in the next IDLE.
- dc_we is sampled only at grant; changes afterwards have no effect.
- rst asserted in any state:
  - Next cycle is the full reset state; the in-flight transaction is abandoned and no done pulse is issued.
  - A mem_done arriving after reset is ignored.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- PARAMS_pkg gains:
  - LINE_BITS = CACHE_LINE_SIZE*8 and LINE_OFF_BITS = $clog2(CACHE_LINE_SIZE).
  - typedef enum arb_state_t {IDLE, ISSUE, RESP}.
  - typedef enum arb_id_t {ARB_IC, ARB_DC}.
- Sub-module rr_arb2: combinational 2-way round-robin picker, (req[1:0], last) -> gnt_valid, gnt_id. The last-grant register stays in mem_arbiter.

Test Plan:
- Reset: hold rst 2 cycles mid-ISSUE -> all outputs 0, state IDLE; a later mem_done pulse produces no ic_done/dc_done.
- Icache read: ic_req, ic_addr = 0x0000_1234; memory returns 0xAA..AA after 3 cycles -> mem_addr = 0x0000_1200, mem_we = 0; ic_done pulses exactly 1 cycle with ic_rdata = 0xAA..AA; dc_done stays 0.
- Dcache writeback: dc_req, dc_we = 1, dc_addr = 0x0000_2040, dc_wdata = 0x55..55 -> mem_we = 1, mem_addr = 0x0000_2040, mem_wdata = 0x55..55 held until mem_done; dc_done pulses 1 cycle later.
- Simultaneous requests out of reset -> icache granted first, dcache second, with grants 4 cycles apart under 1-cycle memory.
- Saturation: both requests re-asserted immediately after every done, 8 transactions -> grant order IC, DC, IC, DC, ...; no requester is granted twice in a row.
- Stray mem_done in IDLE and dc_we toggled during ISSUE -> no done pulse from the stray mem_done; mem_we keeps the value sampled at grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the memory-port arbiter between the icache and dcache refill paths.
package mem_arbiter_pkg;

  localparam int ADDR_SIZE       = 32;
  localparam int CACHE_LINE_SIZE = 64;
  localparam int LINE_BITS       = CACHE_LINE_SIZE * 8;
  localparam int LINE_OFF_BITS   = $clog2(CACHE_LINE_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic       {ARB_IC, ARB_DC}    arb_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker; req_i[0] is the icache, req_i[1] the dcache.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_id_t    last_i,
  output logic       gnt_valid_o,
  output arb_id_t    gnt_id_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = ARB_IC;
    if (req_i[0] && req_i[1])
      gnt_id_o = (last_i == ARB_IC) ? ARB_DC : ARB_IC;
    else if (req_i[1])
      gnt_id_o = ARB_DC;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache refills and dcache refills/writebacks,
// one whole-line transaction at a time, with all outputs registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_SIZE,
  parameter int LINE_BYTES = CACHE_LINE_SIZE,
  localparam int LINE_W    = LINE_BYTES * 8,
  localparam int OFF_W     = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [LINE_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  arb_id_t           last_q, last_d, gnt_q, gnt_d;
  logic              mreq_q, mreq_d, mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [LINE_W-1:0] mwdata_q, mwdata_d, icr_q, icr_d, dcr_q, dcr_d;
  logic              icd_q, icd_d, dcd_q, dcd_d;

  logic    gnt_valid;
  arb_id_t gnt_id;

  rr_arb2 u_rr (
    .req_i       ({dc_req, ic_req}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    icr_d    = icr_q;
    dcr_d    = dcr_q;
    icd_d    = 1'b0;
    dcd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ISSUE;
          gnt_d   = gnt_id;
          last_d  = gnt_id;
          mreq_d  = 1'b1;
          if (gnt_id == ARB_IC) begin
            maddr_d  = {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mwe_d    = 1'b0;
            mwdata_d = '0;
          end else begin
            maddr_d  = {dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mwe_d    = dc_we;
            mwdata_d = dc_wdata;
          end
        end
      end
      ISSUE: begin
        // Only the owner's line register moves; the other requester keeps its last line.
        if (mem_done) begin
          state_d = RESP;
          mreq_d  = 1'b0;
          if (gnt_q == ARB_IC) begin
            icr_d = mem_rdata;
            icd_d = 1'b1;
          end else begin
            dcr_d = mem_rdata;
            dcd_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= ARB_DC;
      gnt_q    <= ARB_IC;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      icr_q    <= '0;
      dcr_q    <= '0;
      icd_q    <= 1'b0;
      dcd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      icr_q    <= icr_d;
      dcr_q    <= dcr_d;
      icd_q    <= icd_d;
      dcd_q    <= dcd_d;
    end
  end

  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign ic_done   = icd_q;
  assign ic_rdata  = icr_q;
  assign dc_done   = dcd_q;
  assign dc_rdata  = dcr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level reference predicts every registered output.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_done, dc_req, dc_we, dc_done;
  logic          mem_req, mem_we, mem_done;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic [LW-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a - (a % 64);
  endfunction

  // Reference: owner 0 = none, 1 = icache, 2 = dcache; arbiter may pick again from cycle free_from.
  int            cyc = 0, owner = 0, free_from = 0, last_w = 2;
  logic          e_mreq = 0, e_mwe = 0, e_icd = 0, e_dcd = 0;
  logic [AW-1:0] e_maddr = '0;
  logic [LW-1:0] e_mwdata = '0, e_icr = '0, e_dcr = '0;
  bit            chk_all = 0;

  task automatic model_edge();
    int w;
    if (rst) begin
      owner = 0; last_w = 2; free_from = cyc + 1; chk_all = 1;
      e_mreq = 0; e_mwe = 0; e_icd = 0; e_dcd = 0;
      e_maddr = '0; e_mwdata = '0; e_icr = '0; e_dcr = '0;
    end else begin
      chk_all = 0; e_icd = 0; e_dcd = 0;
      if (owner != 0) begin
        if (mem_done) begin
          if (owner == 1) begin e_icr = mem_rdata; e_icd = 1; end
          else            begin e_dcr = mem_rdata; e_dcd = 1; end
          e_mreq = 0; owner = 0; free_from = cyc + 2;
        end
      end else if (cyc >= free_from && (ic_req || dc_req)) begin
        if (ic_req && dc_req) w = (last_w == 1) ? 2 : 1;
        else                  w = ic_req ? 1 : 2;
        owner = w; last_w = w; e_mreq = 1;
        if (w == 1) begin e_maddr = align(ic_addr); e_mwe = 0;     e_mwdata = '0;       end
        else        begin e_maddr = align(dc_addr); e_mwe = dc_we; e_mwdata = dc_wdata; end
      end
    end
  endtask

  // Stimulus knobs and memory-responder state
  int   p_ic = 0, p_dc = 0, d_lo = 1, d_hi = 1, m_cnt = 0, last_rise = -1;
  bit   sat = 0, stray = 0, we_toggle = 0, fix_mem = 0;
  bit   m_busy = 0, m_fired = 0, prev_mreq = 0, have_prev = 0, prev_dc = 0;
  logic [LW-1:0] fix_val = '0;

  task automatic drive();
    if (ic_done) ic_req = 0;
    else if (!ic_req && $urandom_range(99) < p_ic) begin ic_req = 1; ic_addr = $urandom; end
    if (dc_done) dc_req = 0;
    else if (!dc_req && $urandom_range(99) < p_dc) begin
      dc_req = 1; dc_addr = $urandom; dc_we = 1'($urandom_range(1)); dc_wdata = rand_line();
    end else if (we_toggle && dc_req) dc_we = 1'($urandom_range(1));
    mem_done = 0;
    if (!mem_req) m_busy = 0;
    else if (!m_busy) begin m_busy = 1; m_fired = 0; m_cnt = $urandom_range(d_hi, d_lo); end
    if (m_busy && !m_fired) begin
      if (m_cnt == 0) begin
        mem_done = 1; m_fired = 1; mem_rdata = fix_mem ? fix_val : rand_line();
      end else m_cnt--;
    end else if (!m_busy && stray && $urandom_range(7) == 0) begin
      mem_done = 1; mem_rdata = rand_line();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("mem_req", LW'(mem_req), LW'(e_mreq));
    if (e_mreq || chk_all) begin
      chk("mem_addr", LW'(mem_addr), LW'(e_maddr));
      chk("mem_we", LW'(mem_we), LW'(e_mwe));
      chk("mem_wdata", mem_wdata, e_mwdata);
    end
    chk("ic_done", LW'(ic_done), LW'(e_icd));
    chk("dc_done", LW'(dc_done), LW'(e_dcd));
    chk("ic_rdata", ic_rdata, e_icr);
    chk("dc_rdata", dc_rdata, e_dcr);
    if (sat) begin
      if (mem_req && !prev_mreq) begin
        if (last_rise >= 0) chk("grant_gap", LW'(cyc - last_rise), LW'(4));
        last_rise = cyc;
      end
      if (ic_done || dc_done) begin
        if (have_prev) chk("alternate", LW'(dc_done), LW'(!prev_dc));
        prev_dc = dc_done; have_prev = 1;
      end
    end
    prev_mreq = mem_req;
    drive();
  endtask

  initial begin
    rst = 1; ic_req = 0; dc_req = 0; dc_we = 0; mem_done = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    step(); step();
    rst = 0;

    // Icache line read, memory answers after 3 cycles with all-AA
    ic_req = 1; ic_addr = 32'h0000_1234;
    fix_mem = 1; fix_val = {16{32'hAAAA_AAAA}}; d_lo = 3; d_hi = 3;
    repeat (12) step();
    chk("ic_line", ic_rdata, {16{32'hAAAA_AAAA}});

    // Dcache writeback
    dc_req = 1; dc_we = 1; dc_addr = 32'h0000_2040; dc_wdata = {16{32'h5555_5555}};
    d_lo = 2; d_hi = 2;
    repeat (12) step();
    fix_mem = 0;

    // Simultaneous requests straight out of reset, then saturation; icache must win first
    rst = 1; step(); rst = 0;
    ic_req = 1; ic_addr = $urandom; dc_req = 1; dc_we = 0; dc_addr = $urandom; dc_wdata = rand_line();
    d_lo = 1; d_hi = 1; p_ic = 100; p_dc = 100;
    sat = 1; last_rise = -1; have_prev = 1; prev_dc = 1;
    repeat (34) step();
    sat = 0;

    // Random traffic with stray mem_done pulses and dc_we wiggling mid-transaction
    p_ic = 30; p_dc = 30; d_lo = 0; d_hi = 4; stray = 1; we_toggle = 1;
    repeat (2000) step();

    // Drain, then reset in the middle of a long transaction and send a late mem_done
    p_ic = 0; p_dc = 0; stray = 0; we_toggle = 0;
    repeat (20) step();
    ic_req = 1; ic_addr = $urandom; d_lo = 6; d_hi = 6;
    for (int i = 0; i < 50 && !mem_req; i++) step();
    chk("wait_issue", LW'(mem_req), LW'(1));
    step();
    rst = 1; ic_req = 0; dc_req = 0;
    step(); step();
    rst = 0;
    mem_done = 1; mem_rdata = rand_line();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
